// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic activation unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stoch_pkg;

  // Activation function selection; 2'b11 behaves as bypass.
  typedef enum logic [1:0] {
    ACT_THRESH = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_BYPASS = 2'b10
  } act_mode_t;

  // Width of the warm-up counter.
  localparam int WARM_W = 16;

endpackage

// File: rtl/stoch_activation_if.sv
// Bitstream bus for the activation unit: controls and streams in, streams and valid out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the producer throttles by dropping en.
// Ports: en/clr/mode/x driven by master, y/y_valid driven by slave.
interface stoch_activation_if #(
  parameter int CHANNELS = 1
);
  logic                en;       // advance all FSMs this cycle
  logic                clr;      // synchronous clear, wins over en
  logic [1:0]          mode;     // 00 thresh, 01 relu, 1x bypass
  logic [CHANNELS-1:0] x;        // input bitstreams
  logic [CHANNELS-1:0] y;        // registered output bitstreams
  logic                y_valid;  // FSMs settled

  modport master (output en, clr, mode, x, input y, y_valid);
  modport slave  (input en, clr, mode, x, output y, y_valid);
endinterface

// File: rtl/stoch_fsm_cell.sv
// One channel: saturating up/down counter FSM producing a tanh/sigmoid/ReLU bitstream.
// Latency: 1 cycle from x to y (y is computed from the next state and registered).
// Backpressure: none; en low freezes state and output.
// Ports: clk, n_rst, en, clr, mode, x, alt (shared toggle) in; y out.
module stoch_fsm_cell
  import stoch_pkg::*;
#(
  parameter int NSTATES = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] mode,
  input  logic       x,
  input  logic       alt,
  output logic       y
);

  localparam int                  STATE_W = $clog2(NSTATES);
  localparam logic [STATE_W-1:0]  S_MID   = STATE_W'(NSTATES / 2);
  localparam logic [STATE_W-1:0]  S_TOP   = STATE_W'(NSTATES - 1);

  logic [STATE_W-1:0] state_q, state_next;
  logic               y_next;
  logic               upper;

  always_comb begin
    state_next = state_q;
    if (x) begin
      if (state_q != S_TOP) state_next = state_q + 1'b1;
    end else begin
      if (state_q != '0) state_next = state_q - 1'b1;
    end

    // Decision is taken on the state being entered, not the current one.
    upper = (state_next >= S_MID);

    y_next = x;
    case (mode)
      ACT_THRESH: y_next = upper;
      // Below the midpoint emit an alternating stream, i.e. bipolar zero.
      ACT_RELU:   y_next = upper ? x : alt;
      default:    y_next = x;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_MID;
      y       <= 1'b0;
    end else if (clr) begin
      state_q <= S_MID;
      y       <= 1'b0;
    end else if (en) begin
      state_q <= state_next;
      y       <= y_next;
    end
  end

endmodule

// File: rtl/stoch_activation.sv
// Multi-channel stochastic activation: per-channel FSM cells plus shared alt toggle and warm-up.
// Latency: 1 cycle x -> y; y_valid rises on the WARMUP-th enabled edge after reset/clear.
// Backpressure: none; en low holds every register.
// Ports: clk, n_rst plain; bus (slave) carries en, clr, mode, x in and y, y_valid out.
module stoch_activation
  import stoch_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int NSTATES  = 8,
  parameter int WARMUP   = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  stoch_activation_if.slave  bus
);

  localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(WARMUP);

  logic              alt_q, alt_next;
  logic [WARM_W-1:0] warm_q, warm_next;
  logic              valid_q, valid_next;
  logic [CHANNELS-1:0] y_bits;

  always_comb begin
    alt_next   = alt_q;
    warm_next  = warm_q;
    valid_next = valid_q;
    if (bus.en) begin
      alt_next = ~alt_q;
      if (warm_q != WARM_MAX) warm_next = warm_q + 1'b1;
      // Sticky: once reached, valid stays up until clear or reset.
      if (warm_next == WARM_MAX) valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      alt_q   <= 1'b0;
      warm_q  <= '0;
      valid_q <= 1'b0;
    end else if (bus.clr) begin
      alt_q   <= 1'b0;
      warm_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      alt_q   <= alt_next;
      warm_q  <= warm_next;
      valid_q <= valid_next;
    end
  end

  // Cells see alt before this edge's toggle.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    stoch_fsm_cell #(.NSTATES(NSTATES)) u_cell (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (bus.en),
      .clr   (bus.clr),
      .mode  (bus.mode),
      .x     (bus.x[i]),
      .alt   (alt_q),
      .y     (y_bits[i])
    );
  end

  assign bus.y       = y_bits;
  assign bus.y_valid = valid_q;

endmodule

// File: tb/tb_stoch_activation.sv
module tb_stoch_activation;

  localparam int CH = 4;
  localparam int NS = 8;
  localparam int WU = 16;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  stoch_activation_if #(.CHANNELS(CH)) bus ();

  stoch_activation #(.CHANNELS(CH), .NSTATES(NS), .WARMUP(WU)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per-channel counter value, shared alternator, warm-up tally.
  int          st [CH];
  bit          m_alt;
  int          m_cnt;
  bit          m_val;
  logic [CH-1:0] m_y;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int c = 0; c < CH; c++) st[c] = NS / 2;
      m_alt = 0; m_cnt = 0; m_val = 0; m_y = '0;
    end else if (bus.clr) begin
      for (int c = 0; c < CH; c++) st[c] = NS / 2;
      m_alt = 0; m_cnt = 0; m_val = 0; m_y = '0;
    end else if (bus.en) begin
      for (int c = 0; c < CH; c++) begin
        int ns;
        if (bus.x[c]) ns = (st[c] + 1 > NS - 1) ? NS - 1 : st[c] + 1;
        else          ns = (st[c] == 0) ? 0 : st[c] - 1;
        case (bus.mode)
          2'd0:    m_y[c] = (ns >= NS / 2);
          2'd1:    m_y[c] = (ns >= NS / 2) ? bus.x[c] : m_alt;
          default: m_y[c] = bus.x[c];
        endcase
        st[c] = ns;
      end
      m_alt = !m_alt;
      if (m_cnt < WU) m_cnt++;
      if (m_cnt == WU) m_val = 1;
    end
  end

  // Every cycle out of reset, outputs must match the model.
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      chk("y_vs_model", 32'(bus.y), 32'(m_y));
      chk("valid_vs_model", 32'(bus.y_valid), 32'(m_val));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int up_s [4] = '{5, 6, 7, 7};
  int dn_s [4] = '{6, 5, 4, 3};
  int dn_y [4] = '{15, 15, 15, 0};
  int ones;

  initial begin
    n_rst    = 1'b0;
    bus.en   = 1'b0;
    bus.clr  = 1'b0;
    bus.mode = 2'b00;
    bus.x    = '0;

    // Reset values without any clock edge.
    #3;
    chk("reset_y", 32'(bus.y), 0);
    chk("reset_valid", 32'(bus.y_valid), 0);
    #4 n_rst = 1'b1;

    // Hold with en low.
    repeat (10) tick();
    chk("hold_y", 32'(bus.y), 0);
    chk("hold_valid", 32'(bus.y_valid), 0);

    // Saturation up then down.
    bus.en = 1'b1;
    bus.x  = '1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sat_up_state", st[0], up_s[k]);
      chk("sat_up_y", 32'(bus.y), 32'hF);
    end
    bus.x = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sat_dn_state", st[0], dn_s[k]);
      chk("sat_dn_y", 32'(bus.y), dn_y[k]);
    end

    // Gap in en must not advance warm-up; edges so far: 8.
    bus.en = 1'b0;
    repeat (3) tick();
    bus.en = 1'b1;
    repeat (7) begin
      bus.x = CH'($urandom);
      tick();
    end
    chk("warm_edge15", 32'(bus.y_valid), 0);
    tick();
    chk("warm_edge16", 32'(bus.y_valid), 1);

    // Clear with en high.
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_state", st[0], 4);
    chk("clr_y", 32'(bus.y), 0);
    chk("clr_valid", 32'(bus.y_valid), 0);

    // Independent channels.
    bus.x = 4'b1010;
    repeat (4) tick();
    chk("multi_ch", 32'(bus.y), 32'b1010);
    repeat (11) tick();
    chk("rewarm_edge15", 32'(bus.y_valid), 0);
    tick();
    chk("rewarm_edge16", 32'(bus.y_valid), 1);

    // Asynchronous reset mid-run.
    @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    chk("async_rst_y", 32'(bus.y), 0);
    chk("async_rst_valid", 32'(bus.y_valid), 0);
    #2 n_rst = 1'b1;

    // ReLU: x=0 drives state below midpoint, output follows alt.
    bus.mode = 2'b01;
    bus.x    = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k < 6) chk("relu_alt", 32'(bus.y[0]), k % 2);
    end
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    bus.x   = '1;
    tick();
    chk("relu_pass", 32'(bus.y), 32'hF);

    // Gain: P(x=1)=0.75 in threshold mode.
    bus.clr = 1'b1;
    tick();
    bus.clr  = 1'b0;
    bus.mode = 2'b00;
    ones = 0;
    repeat (4096) begin
      for (int c = 0; c < CH; c++) bus.x[c] = ($urandom_range(0, 3) != 0);
      tick();
      if (bus.y[0]) ones++;
    end
    checks++;
    if (ones < 3932) begin
      errors++;
      $display("FAIL gain_fraction: ones=%0d of 4096, need >= 3932", ones);
    end

    // Random traffic against the model.
    repeat (3000) begin
      bus.en  = ($urandom_range(0, 3) != 0);
      bus.clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
      bus.x = CH'($urandom);
      tick();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stoch_activation.md
Name: stoch_activation

Overview:
Multi-channel stochastic-computing activation unit for the bitstream network. Each channel applies a saturating up/down counter FSM to its input bitstream. The FSM produces a tanh (bipolar) or sigmoid (unipolar) output stream of parametrised gain, or a ReLU-style stream. It is the parametrised, FSM-based successor to the fixed-gain exponential/fraction sigmoid and sits between neuron adders and the next layer.

Parameters:
CHANNELS, 1, number of independent bitstream channels (1..64)
NSTATES, 8, FSM states per channel; even, 4..256; gain: y = tanh(NSTATES/2 · x) bipolar
WARMUP, 16, enabled cycles after reset/clear before y_valid asserts (1..65535)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
en  input  1  advance all FSMs this cycle; low = hold everything
clr  input  1  synchronous clear of FSM state and warm-up (priority over en)
mode  input  2  00 threshold (tanh/sigmoid), 01 ReLU, 10/11 bypass
x  input  CHANNELS  input bitstreams, one bit per channel per cycle
y  output  CHANNELS  registered output bitstreams
y_valid  output  1  high once FSMs have settled (WARMUP enabled cycles)

Behaviour:
- One clock, asynchronous active-low reset n_rst. Reset: every channel state = NSTATES/2, y = 0, alt = 0, warm-up count = 0, y_valid = 0.
- State width STATE_W = $clog2(NSTATES). Per-channel state s is unsigned in 0..NSTATES-1.
- Enabled edge (en=1, clr=0), per channel:
  - x=1: s_next = min(s+1, NSTATES-1).
  - x=0: s_next = max(s-1, 0).
  - Saturate at both ends with no wrap-around.
- Output is registered with 1-cycle latency and computed from s_next:
  - mode 00: y = (s_next >= NSTATES/2).
  - mode 01: y = x if s_next >= NSTATES/2, else alt (bipolar zero).
  - mode 10/11: y = x. The state still updates.
- alt: single shared toggle flop; inverts on every enabled edge. Value used is alt before the toggle.
- Warm-up counter: 16 bits, increments on enabled edges and saturates at WARMUP. y_valid is registered and set on the enabled edge where the count reaches WARMUP. It stays high until clr or reset.
- en=0, clr=0: all state, y, alt, counter and y_valid hold.
- clr=1 (any en): state = NSTATES/2, y = 0, alt = 0, count = 0, y_valid = 0 on that edge.
- mode change mid-stream: takes effect on the next enabled edge; state is not disturbed.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for clk.

Decomposition:
- Package stoch_pkg:
  - act_mode_t enum (ACT_THRESH=2'b00, ACT_RELU=2'b01, ACT_BYPASS=2'b10)
  - WARM_W = 16
- Sub-module stoch_fsm_cell holds one channel:
  - inputs: clk, n_rst, en, clr, mode, x, alt
  - output: y
  - parameter: NSTATES
- Top module instantiates CHANNELS cells in a generate loop. It owns alt, the warm-up counter and y_valid.

Test Plan:
- Reset/hold: n_rst=0 -> y=0, y_valid=0 without a clk edge. Release, en=0 for 10 cycles -> y, y_valid unchanged.
- Saturation, NSTATES=8, mode 00, en=1:
  - x=1 -> states 5,6,7,7; y=1 from the first edge.
  - Then x=0 -> states 6,5,4,3; y=1,1,1,0.
- Gain, NSTATES=8, mode 00, x from LFSR with P(1)=0.75 (bipolar 0.5), 4096 cycles -> fraction of ones in y = 0.98 ± 0.02.
- ReLU, mode 01:
  - x=0 for 20 cycles -> y alternates 0,1,0,1 after the state drops below 4.
  - x=1 -> y=1 from the first edge.
- Warm-up/clear, WARMUP=16: y_valid rises after exactly the 16th enabled edge, and en gaps do not count. clr=1 with en=1 mid-run -> state 4, y=0, y_valid=0; y_valid rises again 16 enabled edges later.
- Multi-channel, CHANNELS=4: x=4'b1010 constant -> after 4 edges y=4'b1010 in mode 00. Channels must be independent.
